// File: rtl/adc_spi_capture_pkg.sv
// adc_spi_capture_pkg: shared state encoding, default parameters and width helper
package adc_spi_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        QUIET = 2'd3
    } state_t;

    localparam int CLK_DIV_DEF      = 4;
    localparam int FRAME_BITS_DEF   = 16;
    localparam int DATA_W_DEF       = 12;
    localparam int QUIET_CYCLES_DEF = 8;

    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_spi_capture_sclk_gen.sv
// sclk_gen: SCLK divider that idles high and flags each 0->1 toggle as the sample strobe
module sclk_gen
    import adc_spi_capture_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o
);
    localparam int DW = cw(CLK_DIV);

    logic [DW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    // terminal count toggles sclk; disabled divider parks at zero with sclk high
    always_comb begin
        tc          = en_i && (div_q == DW'(CLK_DIV - 1));
        div_d       = (!en_i || tc) ? '0 : div_q + DW'(1);
        sclk_d      = !en_i ? 1'b1 : (tc ? ~sclk_q : sclk_q);
        rise_tick_o = tc && !sclk_q;
    end

    // divider and sclk registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: SPI ADC frame capture with parallel result and one-cycle enable strobe
module adc_spi_capture
    import adc_spi_capture_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int FRAME_BITS   = FRAME_BITS_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int QUIET_CYCLES = QUIET_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sdata,
    output logic              cs_n,
    output logic              sclk,
    output logic [DATA_W-1:0] datos,
    output logic              enable,
    output logic              busy
);
    localparam int BW = cw(FRAME_BITS + 1);
    localparam int QW = cw(QUIET_CYCLES + 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] datos_q, datos_d;
    logic              rise;

    sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk        (clk),
        .rst_n      (reset),
        .en_i       (state_q == SHIFT),
        .sclk_o     (sclk),
        .rise_tick_o(rise)
    );

    // frame sequencing; the shift register keeps only DATA_W bits so header bits fall off the top
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        quiet_d = quiet_q;
        shift_d = shift_q;
        datos_d = datos_q;
        case (state_q)
            IDLE: begin
                bit_d   = '0;
                quiet_d = '0;
                state_d = start ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (rise) begin
                    shift_d = (shift_q << 1) | DATA_W'(sdata);
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(FRAME_BITS - 1)) begin
                        state_d = DONE;
                        datos_d = shift_d;
                    end
                end
            end
            DONE: state_d = QUIET;
            QUIET: begin
                quiet_d = quiet_q + QW'(1);
                state_d = (quiet_q == QW'(QUIET_CYCLES - 1)) ? IDLE : QUIET;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counters, shift and result registers; reset discards any partial frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            quiet_q <= '0;
            shift_q <= '0;
            datos_q <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            quiet_q <= quiet_d;
            shift_q <= shift_d;
            datos_q <= datos_d;
        end
    end

    assign cs_n   = (state_q != SHIFT);
    assign enable = (state_q == DONE);
    assign busy   = (state_q != IDLE);
    assign datos  = datos_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: directed frames against a timeline model of the capture front end
module tb_adc_spi_capture;
    localparam int CD   = 4;
    localparam int FB   = 16;
    localparam int DW   = 12;
    localparam int QC   = 8;
    localparam int FL   = 2 * CD * FB;
    localparam int LAST = FL + 1 + QC;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          sdata = 1'b0;
    logic          cs_n, sclk, enable, busy;
    logic [DW-1:0] datos;

    int tests = 0;
    int fails = 0;

    adc_spi_capture #(.CLK_DIV(CD), .FRAME_BITS(FB), .DATA_W(DW), .QUIET_CYCLES(QC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sdata (sdata),
        .cs_n  (cs_n),
        .sclk  (sclk),
        .datos (datos),
        .enable(enable),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ADC: latch the frame when selected, put the next bit out on each SCLK fall, MSB first
    logic [FB-1:0] frame = '0;
    logic [FB-1:0] adc_fr = '0;
    int            idx = 0;
    always @(negedge cs_n or negedge sclk) begin
        if (!cs_n && sclk) begin
            adc_fr = frame;
            idx    = FB;
        end else if (!cs_n) begin
            idx   = idx - 1;
            sdata = adc_fr[idx];
        end
    end

    // model: k counts cycles since the accepting edge, 0 means idle
    int            k = 0;
    logic [FB-1:0] m_fr = '0;
    logic [DW-1:0] m_datos = '0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            k       = 0;
            m_datos = '0;
        end else if (k == 0) begin
            if (start) begin
                k    = 1;
                m_fr = frame;
            end
        end else begin
            k = (k == LAST) ? 0 : k + 1;
            if (k == FL + 1) m_datos = m_fr[DW-1:0];
        end
    end

    // per-cycle comparison plus bookkeeping of event times for the directed checks
    int   ncyc = 0, t0 = 0, t_cs = 0, t_en = 0, prev_t_en = 0;
    int   n_en = 0, rises = 0, rises_at_en = 0, last_rise = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    always @(negedge clk) begin
        logic act;
        ncyc++;
        act = (k >= 1) && (k <= FL);
        chk("cs_n", int'(cs_n), int'(!act));
        chk("sclk", int'(sclk), act ? int'(((k - 1) / CD) % 2 == 0) : 1);
        chk("enable", int'(enable), int'(k == FL + 1));
        chk("busy", int'(busy), int'(k != 0));
        chk("datos", int'(datos), int'(m_datos));
        if (start && !busy && reset) t0 = ncyc;
        if (prev_cs && !cs_n) begin
            t_cs      = ncyc;
            rises     = 0;
            last_rise = ncyc;
        end
        if (reset && !prev_sclk && sclk) begin
            rises++;
            chk("sclk_rise_spacing", ncyc - last_rise, 2 * CD);
            last_rise = ncyc;
        end
        if (enable) begin
            n_en++;
            prev_t_en   = t_en;
            t_en        = ncyc;
            rises_at_en = rises;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_en(input int bound);
        int n0 = n_en;
        int ok = 0;
        for (int i = 0; i < bound && ok == 0; i++) begin
            step(1);
            if (n_en != n0) ok = 1;
        end
        chk("enable_timeout", ok, 1);
    endtask

    task automatic wait_idle(input int bound);
        int ok = 0;
        for (int i = 0; i < bound && ok == 0; i++) begin
            step(1);
            if (!busy) ok = 1;
        end
        chk("idle_timeout", ok, 1);
    endtask

    task automatic run_frame(input logic [FB-1:0] fr, input int exp_d);
        frame = fr;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_en(FL + 20);
        chk("frame_datos", int'(datos), exp_d);
        chk("cs_fall_latency", t_cs - t0, 1);
        chk("enable_latency", t_en - t0, FL + 1);
        chk("rises_per_frame", rises_at_en, FB);
        wait_idle(QC + 5);
    endtask

    initial begin
        int e1, n0, ok;
        step(3);
        reset = 1'b1;
        step(20);
        chk("idle_cs_n", int'(cs_n), 1);
        chk("idle_sclk", int'(sclk), 1);
        chk("idle_datos", int'(datos), 0);
        chk("idle_enable_count", n_en, 0);

        run_frame(16'h0A5C, 12'hA5C);
        chk("single_enable", n_en, 1);
        run_frame(16'hF123, 12'h123);

        frame = 16'h0FFF;
        start = 1'b1;
        wait_en(FL + 20);
        chk("b2b_first", int'(datos), 12'hFFF);
        e1    = t_en;
        frame = 16'h0001;
        wait_en(FL + QC + 20);
        start = 1'b0;
        chk("b2b_second", int'(datos), 12'h001);
        chk("b2b_spacing", t_en - e1, 138);
        chk("b2b_prev_enable", prev_t_en, e1);
        wait_idle(QC + 5);
        step(2);

        n0    = n_en;
        frame = 16'h0333;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(40);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        wait_idle(FL + QC + 20);
        chk("ignored_start_enables", n_en - n0, 1);
        chk("ignored_start_datos", int'(datos), 12'h333);
        step(3);

        n0    = n_en;
        frame = 16'h0777;
        start = 1'b1;
        step(1);
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < FL && ok == 0; i++) begin
            step(1);
            if (rises >= 9) ok = 1;
        end
        chk("ninth_bit_timeout", ok, 1);
        step(2);
        reset = 1'b0;
        #1;
        chk("abort_cs_n", int'(cs_n), 1);
        chk("abort_sclk", int'(sclk), 1);
        chk("abort_datos", int'(datos), 0);
        chk("abort_busy", int'(busy), 0);
        step(2);
        reset = 1'b1;
        step(FL);
        chk("abort_no_enable", n_en - n0, 0);
        chk("abort_datos_held", int'(datos), 0);
        run_frame(16'h5ABC, 12'hABC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
